// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler: FSM states, lamp codes, road ids.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_GRN    = 2'd0,
      ST_YEL    = 2'd1,
      ST_ALLRED = 2'd2,
      ST_WALK   = 2'd3
   } state_t;

   // Lamp codes are {R,Y,G}
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   localparam logic ROAD_A = 1'b0;
   localparam logic ROAD_B = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Divides the system clock into a one-cycle enable pulse every TICK_DIV cycles.
// The pulse is combinational from the counter; first pulse lands TICK_DIV cycles after reset.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase controller: green/yellow/all-red/walk sequencing with green extension.
// A single 6-bit counter serves as the countdown timer in timed phases and as elapsed time in green.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned GREEN_MIN = 10,
   parameter int unsigned GREEN_MAX = 25,
   parameter int unsigned YELLOW_T  = 5,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned WALK_T    = 8
) (
   input  logic       CLK50MHz,
   input  logic       RST,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       ped_req,
   output logic [2:0] light_a,
   output logic [2:0] light_b,
   output logic       walk,
   output logic       ped_ack,
   output logic [5:0] remain,
   output logic [2:0] phase
);

   if (GREEN_MIN < 1 || GREEN_MIN > 63 || GREEN_MAX < GREEN_MIN || GREEN_MAX > 63 ||
       YELLOW_T < 1 || YELLOW_T > 63 || ALLRED_T < 1 || ALLRED_T > 63 ||
       WALK_T < 1 || WALK_T > 63) begin : g_bad_param
      $error("traffic_phase_scheduler: phase durations must lie in 1..63 with GREEN_MIN <= GREEN_MAX");
   end

   localparam logic [5:0] GMIN6   = 6'(GREEN_MIN);
   localparam logic [5:0] GMAX6   = 6'(GREEN_MAX);
   localparam logic [6:0] GMIN7   = 7'(GREEN_MIN);
   localparam logic [6:0] GMAX7   = 7'(GREEN_MAX);
   localparam logic [5:0] YEL6    = 6'(YELLOW_T);
   localparam logic [5:0] ALLRED6 = 6'(ALLRED_T);
   localparam logic [5:0] WALK6   = 6'(WALK_T);

   logic tick;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (CLK50MHz),
      .rst  (RST),
      .tick (tick)
   );

   state_t     state, state_n;
   logic       owner, owner_n;
   logic       next_road, next_road_n;
   logic [5:0] cnt, cnt_n;
   logic       dem_a, dem_a_n, dem_b, dem_b_n;
   logic       ped_pend, ped_pend_n, ped_q;
   logic       ack, ack_n;

   logic       ped_rise, eff_a, eff_b, eff_ped, own_dem, opp_dem;
   logic [6:0] e_inc;

   always_ff @(posedge CLK50MHz or posedge RST) begin
      if (RST) begin
         state     <= ST_ALLRED;
         owner     <= ROAD_A;
         next_road <= ROAD_A;
         cnt       <= ALLRED6;
         dem_a     <= 1'b0;
         dem_b     <= 1'b0;
         ped_pend  <= 1'b0;
         ped_q     <= 1'b0;
         ack       <= 1'b0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         next_road <= next_road_n;
         cnt       <= cnt_n;
         dem_a     <= dem_a_n;
         dem_b     <= dem_b_n;
         ped_pend  <= ped_pend_n;
         ped_q     <= ped_req;
         ack       <= ack_n;
      end
   end

   // Live inputs are OR-ed with the latches so a request on the deciding tick still counts
   always_comb begin
      ped_rise    = ped_req & ~ped_q;
      eff_a       = dem_a | req_a;
      eff_b       = dem_b | req_b;
      eff_ped     = ped_pend | ped_rise;
      own_dem     = (owner == ROAD_B) ? eff_b : eff_a;
      opp_dem     = (owner == ROAD_B) ? eff_a : eff_b;
      e_inc       = {1'b0, cnt} + 7'd1;

      state_n     = state;
      owner_n     = owner;
      next_road_n = next_road;
      cnt_n       = cnt;
      dem_a_n     = eff_a;
      dem_b_n     = eff_b;
      ped_pend_n  = eff_ped;
      ack_n       = 1'b0;

      if (tick) begin
         case (state)
            ST_GRN: begin
               if (e_inc >= GMIN7 && (opp_dem || eff_ped) && (!own_dem || e_inc >= GMAX7)) begin
                  state_n     = ST_YEL;
                  cnt_n       = YEL6;
                  next_road_n = ~next_road;
               end else begin
                  cnt_n = (e_inc >= GMAX7) ? GMAX6 : e_inc[5:0];
               end
            end
            ST_YEL: begin
               if (cnt <= 6'd1) begin
                  state_n = ST_ALLRED;
                  cnt_n   = ALLRED6;
               end else begin
                  cnt_n = cnt - 6'd1;
               end
            end
            ST_ALLRED, ST_WALK: begin
               if (cnt > 6'd1) begin
                  cnt_n = cnt - 6'd1;
               end else if (state == ST_ALLRED && eff_ped) begin
                  state_n    = ST_WALK;
                  cnt_n      = WALK6;
                  ped_pend_n = 1'b0;
                  ack_n      = 1'b1;
               end else begin
                  state_n = ST_GRN;
                  owner_n = next_road;
                  cnt_n   = 6'd0;
                  if (next_road == ROAD_A)
                     dem_a_n = 1'b0;
                  else
                     dem_b_n = 1'b0;
               end
            end
            default: begin
               state_n = ST_ALLRED;
               cnt_n   = ALLRED6;
            end
         endcase
      end
   end

   logic [2:0] own_light;

   always_comb begin
      case (state)
         ST_GRN:  own_light = LT_GRN;
         ST_YEL:  own_light = LT_YEL;
         default: own_light = LT_RED;
      endcase
      light_a = (owner == ROAD_A) ? own_light : LT_RED;
      light_b = (owner == ROAD_B) ? own_light : LT_RED;
      walk    = (state == ST_WALK);
      ped_ack = ack;
      if (state == ST_GRN)
         remain = (cnt < GMIN6) ? (GMIN6 - cnt) : 6'd0;
      else
         remain = cnt;
      phase   = {owner, state};
   end

endmodule
